// File: rtl/peripheral_uart_tx.sv
// ============================================================================
// Module   : peripheral_uart_tx
// Purpose  : Memory-mapped buffered UART transmitter for the J1 I/O bus with a
//            TX FIFO, programmable baud divisor, enable/flush control, status.
//            Optional parity frame bit is built when UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Register file and FIFO state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              enable_q, enable_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       div_q, div_d;
`ifdef UART_PARITY_EN
  logic              odd_q, odd_d;
  logic              par_q, par_d;
`endif

  // Shifter state
  state_e            state_q, state_d;
  logic [15:0]       timer_q, timer_d;
  logic [15:0]       frame_div_q, frame_div_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;

  logic              push_req, ctrl_wr, flush, push_acc, pop, start_frame;
  logic              full, empty, bit_end, can_start;
  logic [DATA_W-1:0] head;
  logic [4:0]        count5;

  assign push_req = cs && wr && (addr == 4'h0);
  assign ctrl_wr  = cs && wr && (addr == 4'h4);
  assign flush    = ctrl_wr && d_in[2];
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign count5   = 5'(count_q);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_acc = push_req && !flush && (!full || pop);
  assign tx       = tx_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    enable_d = enable_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
`ifdef UART_PARITY_EN
    odd_d    = odd_q;
`endif
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_acc) - CW'(pop);
    end
    if (push_req && !flush && full && !pop) ovf_d = 1'b1;
    if (ctrl_wr) begin
      enable_d = d_in[0];
      if (d_in[1]) ovf_d = 1'b0;
`ifdef UART_PARITY_EN
      odd_d = d_in[3];
`endif
    end
    if (cs && wr && (addr == 4'h2)) div_d = (d_in == 16'd0) ? 16'd1 : d_in;
  end

  assign bit_end   = (timer_q == frame_div_q - 16'd1);
  assign can_start = enable_q && !empty;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    frame_div_d = frame_div_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
`ifdef UART_PARITY_EN
    par_d       = par_q;
`endif
    pop         = 1'b0;
    start_frame = 1'b0;
    tx_d        = 1'b1;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (can_start) start_frame = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          timer_d   = '0;
          bit_idx_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_idx_q == 3'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = shreg_q >> 1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (can_start) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The divisor is captured per frame so a DIV write only affects later frames.
    if (start_frame) begin
      pop         = 1'b1;
      state_d     = S_START;
      timer_d     = '0;
      shreg_d     = head;
      frame_div_d = div_q;
`ifdef UART_PARITY_EN
      par_d       = (^head) ^ odd_q;
`endif
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= d_in[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b1;
      ovf_q       <= 1'b0;
      div_q       <= 16'(DIV_RESET);
`ifdef UART_PARITY_EN
      odd_q       <= 1'b0;
      par_q       <= 1'b0;
`endif
      state_q     <= S_IDLE;
      timer_q     <= '0;
      frame_div_q <= 16'(DIV_RESET);
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      ovf_q       <= ovf_d;
      div_q       <= div_d;
`ifdef UART_PARITY_EN
      odd_q       <= odd_d;
      par_q       <= par_d;
`endif
      state_q     <= state_d;
      timer_q     <= timer_d;
      frame_div_q <= frame_div_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    d_out = '0;
    if (cs && rd) begin
      case (addr)
        4'h6: d_out = {3'b000, count5, 3'b000, enable_q, ovf_q, empty, full,
                       (state_q != S_IDLE) || !empty};
        4'h8: d_out = div_q;
`ifdef UART_PARITY_EN
        4'hA: d_out = {12'd0, odd_q, 2'b00, enable_q};
`else
        4'hA: d_out = {15'd0, enable_q};
`endif
        default: d_out = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/peripheral_uart_tx.md
# peripheral_uart_tx

Memory-mapped, parametrised UART transmitter peripheral for the J1 SoC I/O bus. It replaces the single-byte, busy-flag command sender with a buffered transmitter that has a transmit FIFO, a programmable baud divisor, enable/flush control and a readable status word. It decodes the 4 LSBs of the J1 I/O address when chip-selected and drives a single serial `tx` line (8N1 by default, optional parity).

## Interface
Parameters:
- `DATA_W`, 8: frame data bits, legal range 5..8; taken from `d_in[DATA_W-1:0]`.
- `FIFO_DEPTH`, 16: number of TX FIFO entries; must be a power of two, 2..16.
- `DIV_RESET`, 434: reset value of the baud divisor (50 MHz / 115200).

Ports:
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `d_in` in 16: write data from the J1.
- `cs` in 1: peripheral chip select.
- `addr` in 4: register address (4 LSBs of the J1 I/O address).
- `rd` in 1: read strobe.
- `wr` in 1: write strobe.
- `d_out` out 16: read data; combinational.
- `tx` out 1: serial output; idle high.

## Operation
- Write decode is `cs && wr`, sampled at the rising edge:
  - `0x0` DATA: push `d_in[DATA_W-1:0]` into the FIFO.
  - `0x2` DIV: baud divisor = `d_in[15:0]`. A value of 0 is stored as 1.
  - `0x4` CTRL:
    - bit0 sets ENABLE (level).
    - bit1 writes 1 to clear OVERFLOW.
    - bit2 writes 1 to flush the FIFO.
    - bits 1 and 2 are self-clearing.
- Read decode is `cs && rd`. `d_out` is 0 whenever `cs && rd` is false or the address is unmapped.
  - `0x6` STATUS:
    - bit0 BUSY: shifter not idle, or FIFO not empty.
    - bit1 FULL.
    - bit2 EMPTY.
    - bit3 OVERFLOW (sticky).
    - bit4 ENABLE.
    - bits[12:8] FIFO count.
    - all other bits are 0.
  - `0x8` DIV readback.
  - `0xA` CTRL readback: bit0 ENABLE.
- FIFO behaviour:
  - A push when full is dropped and sets OVERFLOW. Exception: a pop in the same cycle makes room, so that push is accepted with no overflow.
  - Flush empties the FIFO. Flush and push in the same cycle: flush wins, the byte is dropped, OVERFLOW is not set.
  - CTRL writing bit1 and bit2 together: both actions happen.
- Shifter FSM:
  - States: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE -> START when ENABLE=1 and FIFO not empty. In that cycle the head entry is popped into the shift register and the divisor is latched for the whole frame.
  - START, DATA, PARITY and STOP each hold for one bit period of DIV clocks per bit. DATA sends DATA_W bits, LSB first.
  - STOP -> START directly (back-to-back frames, no idle gap) if ENABLE=1 and FIFO not empty; otherwise STOP -> IDLE.
  - `tx` values: 0 in START, data bit in DATA, 1 in STOP and IDLE.
- Mid-operation changes:
  - Clearing ENABLE mid-frame: the current frame completes; no further pops.
  - Flush mid-frame: the current frame completes; the queued bytes are discarded.
  - DIV write mid-frame: takes effect from the next frame.

## Timing
- Reset values:
  - `tx`=1, `d_out`=0.
  - FSM=IDLE, FIFO empty, count=0.
  - OVERFLOW=0, ENABLE=1, DIV=`DIV_RESET`.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously) and all queued data is lost.
- Latency with FIFO empty, enabled and idle:
  - DATA write at edge k makes the FIFO non-empty.
  - Pop and transition to START happen at edge k+1; `tx` falls after edge k+1.
- Frame length = (1 + DATA_W + P + 1) × DIV cycles, where P = 1 with parity and 0 without. A back-to-back next frame starts on the cycle after the last STOP cycle.
- STATUS reflects register state as of the last edge; there is no read side effect.
- Bit timer: counts 0..DIV-1 and advances the bit at DIV-1. The 16-bit counter never wraps, because DIV ≤ 0xFFFF.

## Configuration
- `UART_PARITY_EN`:
  - Defined: the PARITY state is inserted after DATA. CTRL bit3 selects odd parity (1) or even parity (0); it resets to 0 and reads back at CTRL bit3 (`0xA`).
  - Undefined: no PARITY state, CTRL bit3 is ignored and reads 0; frames are 8N1 when DATA_W=8.

## Test plan
- DIV=4, write DATA 0xA5 -> after `tx` falls: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; 40 cycles total. BUSY=1 throughout, 0 afterwards.
- ENABLE=0, write 17 bytes -> STATUS FULL=1, count=16, OVERFLOW=1. CTRL=0x3 (enable plus clear overflow) -> 16 frames are sent back-to-back with no idle gap between frames, and the 17th byte is never sent.
- Mid-frame flush with 3 bytes queued -> the current frame ends normally, then `tx` stays 1, EMPTY=1, BUSY=0.
- DIV write of 0 -> DIV readback = 1; each bit lasts 1 cycle.
- Assert `rst` mid-DATA -> `tx`=1 immediately; STATUS = 0x0014 (EMPTY, ENABLE); DIV readback = 434.
- With `UART_PARITY_EN`, even parity, DIV=2, byte 0xA5 -> parity bit 0; with odd parity the parity bit is 1. Frame length is 22 cycles.
